// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter / return-address-stack unit.
// Holds the command encoding, the strobe priority encoder and default sizes.
package pc_pkg;

    localparam int unsigned PC_AW_DEFAULT        = 16;
    localparam int unsigned PC_OFF_W_DEFAULT     = 8;
    localparam int unsigned PC_RAS_DEPTH_DEFAULT = 4;

    typedef enum logic [2:0] {
        CMD_HOLD,
        CMD_INC,
        CMD_BR,
        CMD_RET,
        CMD_CALL,
        CMD_LOAD,
        CMD_STALL
    } pc_cmd_e;

    // Collapse the raw strobes into the single action taken this cycle.
    // Order: stall > load > call > ret > br > inc > hold (rst handled by the caller).
    function automatic pc_cmd_e pc_prio_encode(
        input logic stall,
        input logic load,
        input logic call,
        input logic ret,
        input logic br,
        input logic inc
    );
        pc_cmd_e cmd;
        if (stall)     cmd = CMD_STALL;
        else if (load) cmd = CMD_LOAD;
        else if (call) cmd = CMD_CALL;
        else if (ret)  cmd = CMD_RET;
        else if (br)   cmd = CMD_BR;
        else if (inc)  cmd = CMD_INC;
        else           cmd = CMD_HOLD;
        return cmd;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push when full overwrites the oldest entry;
// a pop when empty leaves the stack untouched. Both cases raise a one-cycle
// event pulse (combinational, qualified by the request) for the caller.
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned AW        = PC_AW_DEFAULT,
    parameter int unsigned RAS_DEPTH = PC_RAS_DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [AW-1:0] i_push_data,
    output logic [AW-1:0] o_top,
    output logic          o_empty,
    output logic          o_full,
    output logic          o_ovf,
    output logic          o_unf
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] r_wp;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_mem [RAS_DEPTH];
    logic [PW-1:0] w_rd_ptr;

    assign w_rd_ptr = r_wp - PW'(1);
    assign o_top    = r_mem[w_rd_ptr];
    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == CW'(RAS_DEPTH));
    assign o_ovf    = i_push & o_full;
    assign o_unf    = i_pop & o_empty;

    // Write pointer and occupancy; count saturates because overflow just wraps wp.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_count <= '0;
        end else if (i_push) begin
            r_wp <= r_wp + PW'(1);
            if (!o_full) begin
                r_count <= r_count + CW'(1);
            end
        end else if (i_pop && !o_empty) begin
            r_wp    <= r_wp - PW'(1);
            r_count <= r_count - CW'(1);
        end
    end

    // Entry storage; contents are meaningless after reset so no reset is applied.
    always_ff @(posedge clk) begin
        if (i_push && !rst) begin
            r_mem[r_wp] <= i_push_data;
        end
    end

endmodule

// File: rtl/pc_ras_unit.sv
// Program counter with stall, absolute load, relative branch and call/return
// backed by a hardware return-address stack.
// Optional sticky overflow/underflow flags are enabled by defining PC_RAS_ERR_EN.
module pc_ras_unit
    import pc_pkg::*;
#(
    parameter int unsigned   AW        = PC_AW_DEFAULT,
    parameter int unsigned   OFF_W     = PC_OFF_W_DEFAULT,
    parameter int unsigned   RAS_DEPTH = PC_RAS_DEPTH_DEFAULT,
    parameter logic [AW-1:0] RESET_VEC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             inc,
    input  logic             load,
    input  logic             br,
    input  logic             call,
    input  logic             ret,
    input  logic [AW-1:0]    tgt,
    input  logic [OFF_W-1:0] off,
`ifdef PC_RAS_ERR_EN
    input  logic             err_clr,
    output logic             err_ovf,
    output logic             err_unf,
`endif
    output logic [AW-1:0]    pc,
    output logic             ras_empty,
    output logic             ras_full
);

    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_nxt;
    logic [AW-1:0] w_pc_inc;
    logic [AW-1:0] w_pc_br;
    logic [AW-1:0] w_off_ext;
    logic [AW-1:0] w_ras_top;
    logic          w_push;
    logic          w_pop;
    logic          w_ovf;
    logic          w_unf;
    pc_cmd_e       w_cmd;

    assign w_cmd     = pc_prio_encode(stall, load, call, ret, br, inc);
    assign w_push    = (w_cmd == CMD_CALL);
    assign w_pop     = (w_cmd == CMD_RET);
    assign w_pc_inc  = r_pc + AW'(1);
    assign w_off_ext = AW'($signed(off));
    assign w_pc_br   = r_pc + w_off_ext;

    pc_ras #(
        .AW        (AW),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_pc_inc),
        .o_top       (w_ras_top),
        .o_empty     (ras_empty),
        .o_full      (ras_full),
        .o_ovf       (w_ovf),
        .o_unf       (w_unf)
    );

    // Next-pc mux; a return on an empty stack falls through to pc+1.
    always_comb begin
        w_pc_nxt = r_pc;
        case (w_cmd)
            CMD_LOAD: w_pc_nxt = tgt;
            CMD_CALL: w_pc_nxt = tgt;
            CMD_RET:  w_pc_nxt = ras_empty ? w_pc_inc : w_ras_top;
            CMD_BR:   w_pc_nxt = w_pc_br;
            CMD_INC:  w_pc_nxt = w_pc_inc;
            default:  w_pc_nxt = r_pc;
        endcase
    end

    // Program counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_VEC;
        end else begin
            r_pc <= w_pc_nxt;
        end
    end

    assign pc = r_pc;

`ifdef PC_RAS_ERR_EN
    logic r_err_ovf;
    logic r_err_unf;

    // Sticky error flags; a clear wins over a same-cycle event.
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            if (w_ovf) r_err_ovf <= 1'b1;
            if (w_unf) r_err_unf <= 1'b1;
        end
    end

    assign err_ovf = r_err_ovf;
    assign err_unf = r_err_unf;
`else
    // Events are dropped when the error flags are not built.
    logic w_unused_ev;
    assign w_unused_ev = w_ovf | w_unf;
`endif

endmodule

// File: tb/tb_pc_ras_unit.sv
// Self-checking bench for pc_ras_unit: directed scenarios plus randomized
// strobes checked against a queue-based reference model.
module tb_pc_ras_unit;

    localparam logic [15:0] RV = 16'h0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, inc = 1'b0, load = 1'b0, br = 1'b0, call = 1'b0, ret = 1'b0;
    logic [15:0] tgt = '0;
    logic [7:0]  off = '0;
    logic        err_clr = 1'b0;
    logic [15:0] pc;
    logic        ras_empty, ras_full;
`ifdef PC_RAS_ERR_EN
    logic        err_ovf, err_unf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [15:0] m_pc;
    logic [15:0] m_ras [$];
    bit          m_ovf, m_unf;

    always #5 clk = ~clk;

    pc_ras_unit #(
        .AW        (16),
        .OFF_W     (8),
        .RAS_DEPTH (4),
        .RESET_VEC (RV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .inc       (inc),
        .load      (load),
        .br        (br),
        .call      (call),
        .ret       (ret),
        .tgt       (tgt),
        .off       (off),
`ifdef PC_RAS_ERR_EN
        .err_clr   (err_clr),
        .err_ovf   (err_ovf),
        .err_unf   (err_unf),
`endif
        .pc        (pc),
        .ras_empty (ras_empty),
        .ras_full  (ras_full)
    );

    // Apply one cycle of stimulus, advance the model, sample 1ns after the edge.
    task automatic step(input logic r, input logic s, input logic ld, input logic cl,
                        input logic rt, input logic b, input logic in,
                        input logic [15:0] t, input logic [7:0] o);
        logic [15:0] sext;
        bit ev_o, ev_u;
        rst = r; stall = s; load = ld; call = cl; ret = rt; br = b; inc = in;
        tgt = t; off = o;
        @(posedge clk);
        ev_o = 0; ev_u = 0;
        if (r) begin
            m_pc = RV;
            m_ras.delete();
            m_ovf = 0; m_unf = 0;
        end else begin
            if (s) begin
            end else if (ld) begin
                m_pc = t;
            end else if (cl) begin
                if (m_ras.size() == 4) begin
                    void'(m_ras.pop_front());
                    ev_o = 1;
                end
                m_ras.push_back(m_pc + 16'd1);
                m_pc = t;
            end else if (rt) begin
                if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                else begin
                    m_pc = m_pc + 16'd1;
                    ev_u = 1;
                end
            end else if (b) begin
                sext = {{8{o[7]}}, o};
                m_pc = m_pc + sext;
            end else if (in) begin
                m_pc = m_pc + 16'd1;
            end
            if (err_clr) begin
                m_ovf = 0; m_unf = 0;
            end else begin
                m_ovf = m_ovf | ev_o;
                m_unf = m_unf | ev_u;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0, 0, 16'h0, 8'h0);
        step(1, 0, 1, 1, 0, 0, 1, 16'h1234, 8'h0);
        n_checks++;
        if (pc !== 16'h0100) begin
            n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, 16'h0100);
        end
        n_checks++;
        if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got empty=%b full=%b expected 1 0",
                               ras_empty, ras_full);
        end
    endtask

    task automatic test_inc();
        logic [15:0] exp_pc [3];
        exp_pc[0] = 16'h0101; exp_pc[1] = 16'h0102; exp_pc[2] = 16'h0103;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 1, 16'h0, 8'h0);
            n_checks++;
            if (pc !== exp_pc[i] || ras_empty !== 1'b1) begin
                n_fail++; $display("FAIL inc_%0d: got pc=%h empty=%b expected pc=%h empty=1",
                                   i, pc, ras_empty, exp_pc[i]);
            end
        end
    endtask

    task automatic test_branch_wrap();
        step(0, 0, 1, 0, 0, 0, 0, 16'h0002, 8'h0);
        step(0, 0, 0, 0, 0, 1, 0, 16'h0, 8'hFC);
        n_checks++;
        if (pc !== 16'hFFFE) begin
            n_fail++; $display("FAIL br_back_wrap: got %h expected FFFE", pc);
        end
        step(0, 0, 0, 0, 0, 1, 0, 16'h0, 8'h05);
        n_checks++;
        if (pc !== 16'h0003) begin
            n_fail++; $display("FAIL br_fwd_wrap: got %h expected 0003", pc);
        end
        step(0, 0, 1, 0, 0, 0, 0, 16'hFFFF, 8'h0);
        step(0, 0, 0, 0, 0, 0, 1, 16'h0, 8'h0);
        n_checks++;
        if (pc !== 16'h0000) begin
            n_fail++; $display("FAIL inc_wrap: got %h expected 0000", pc);
        end
    endtask

    task automatic test_nested_call();
        step(0, 0, 1, 0, 0, 0, 0, 16'h0010, 8'h0);
        n_checks++;
        if (ras_empty !== 1'b1) begin
            n_fail++; $display("FAIL nest_empty0: got %b expected 1", ras_empty);
        end
        step(0, 0, 0, 1, 0, 0, 0, 16'h0200, 8'h0);
        n_checks++;
        if (pc !== 16'h0200 || ras_empty !== 1'b0) begin
            n_fail++; $display("FAIL nest_call1: got pc=%h empty=%b expected 0200 0", pc, ras_empty);
        end
        step(0, 0, 0, 1, 0, 0, 0, 16'h0300, 8'h0);
        n_checks++;
        if (pc !== 16'h0300 || ras_empty !== 1'b0) begin
            n_fail++; $display("FAIL nest_call2: got pc=%h empty=%b expected 0300 0", pc, ras_empty);
        end
        step(0, 0, 0, 0, 1, 0, 0, 16'h0, 8'h0);
        n_checks++;
        if (pc !== 16'h0201 || ras_empty !== 1'b0) begin
            n_fail++; $display("FAIL nest_ret1: got pc=%h empty=%b expected 0201 0", pc, ras_empty);
        end
        step(0, 0, 0, 0, 1, 0, 0, 16'h0, 8'h0);
        n_checks++;
        if (pc !== 16'h0011 || ras_empty !== 1'b1) begin
            n_fail++; $display("FAIL nest_ret2: got pc=%h empty=%b expected 0011 1", pc, ras_empty);
        end
    endtask

    task automatic test_ovf_unf();
        logic [15:0] exp_ret [4];
        logic [15:0] from;
        exp_ret[0] = 16'h0051; exp_ret[1] = 16'h0041; exp_ret[2] = 16'h0031; exp_ret[3] = 16'h0021;
        step(1, 0, 0, 0, 0, 0, 0, 16'h0, 8'h0);
        for (int i = 1; i <= 5; i++) begin
            from = 16'(i * 16);
            step(0, 0, 1, 0, 0, 0, 0, from, 8'h0);
            step(0, 0, 0, 1, 0, 0, 0, 16'h0800 + from, 8'h0);
        end
        n_checks++;
        if (ras_full !== 1'b1 || pc !== 16'h0850) begin
            n_fail++; $display("FAIL ovf_full: got full=%b pc=%h expected 1 0850", ras_full, pc);
        end
`ifdef PC_RAS_ERR_EN
        n_checks++;
        if (err_ovf !== 1'b1 || err_unf !== 1'b0) begin
            n_fail++; $display("FAIL ovf_flag: got ovf=%b unf=%b expected 1 0", err_ovf, err_unf);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1, 0, 0, 16'h0, 8'h0);
            n_checks++;
            if (pc !== exp_ret[i]) begin
                n_fail++; $display("FAIL ovf_ret_%0d: got %h expected %h", i, pc, exp_ret[i]);
            end
        end
        n_checks++;
        if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin
            n_fail++; $display("FAIL drained: got empty=%b full=%b expected 1 0", ras_empty, ras_full);
        end
        step(0, 0, 0, 0, 1, 0, 0, 16'h0, 8'h0);
        n_checks++;
        if (pc !== 16'h0022 || ras_empty !== 1'b1) begin
            n_fail++; $display("FAIL unf_ret: got pc=%h empty=%b expected 0022 1", pc, ras_empty);
        end
`ifdef PC_RAS_ERR_EN
        n_checks++;
        if (err_unf !== 1'b1) begin
            n_fail++; $display("FAIL unf_flag: got %b expected 1", err_unf);
        end
`endif
    endtask

    task automatic test_priority_stall();
        step(1, 0, 0, 0, 0, 0, 0, 16'h0, 8'h0);
        step(0, 0, 1, 0, 0, 0, 0, 16'h0010, 8'h0);
        step(0, 0, 0, 1, 0, 0, 0, 16'h0050, 8'h0);
        step(0, 1, 1, 1, 0, 0, 1, 16'h0777, 8'h0);
        n_checks++;
        if (pc !== 16'h0050 || ras_empty !== 1'b0) begin
            n_fail++; $display("FAIL stall_hold: got pc=%h empty=%b expected 0050 0", pc, ras_empty);
        end
        step(0, 0, 1, 1, 0, 0, 1, 16'h0400, 8'h0);
        n_checks++;
        if (pc !== 16'h0400) begin
            n_fail++; $display("FAIL load_prio: got %h expected 0400", pc);
        end
        step(0, 0, 0, 0, 1, 0, 0, 16'h0, 8'h0);
        n_checks++;
        if (pc !== 16'h0011 || ras_empty !== 1'b1) begin
            n_fail++; $display("FAIL prio_count: got pc=%h empty=%b expected 0011 1", pc, ras_empty);
        end
    endtask

    task automatic test_reset_mid();
        step(0, 0, 1, 0, 0, 0, 0, 16'h0010, 8'h0);
        step(0, 0, 0, 1, 0, 0, 0, 16'h0020, 8'h0);
        step(0, 0, 0, 1, 0, 0, 0, 16'h0030, 8'h0);
        step(1, 1, 0, 1, 0, 0, 0, 16'h0040, 8'h0);
        n_checks++;
        if (pc !== RV || ras_empty !== 1'b1 || ras_full !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid: got pc=%h empty=%b full=%b expected %h 1 0",
                               pc, ras_empty, ras_full, RV);
        end
`ifdef PC_RAS_ERR_EN
        n_checks++;
        if (err_ovf !== 1'b0 || err_unf !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_err: got %b %b expected 0 0", err_ovf, err_unf);
        end
`endif
        step(0, 0, 0, 0, 1, 0, 0, 16'h0, 8'h0);
        n_checks++;
        if (pc !== 16'h0101) begin
            n_fail++; $display("FAIL rst_mid_unf: got %h expected 0101", pc);
        end
    endtask

    task automatic test_random();
        logic r, s, ld, cl, rt, b, in;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 99) < 2);
            s  = ($urandom_range(0, 99) < 10);
            ld = ($urandom_range(0, 99) < 15);
            cl = ($urandom_range(0, 99) < 35);
            rt = ($urandom_range(0, 99) < 35);
            b  = ($urandom_range(0, 99) < 30);
            in = ($urandom_range(0, 99) < 40);
            err_clr = ($urandom_range(0, 99) < 5);
            step(r, s, ld, cl, rt, b, in, 16'($urandom), 8'($urandom));
            n_checks++;
            if (pc !== m_pc || ras_empty !== (m_ras.size() == 0) ||
                ras_full !== (m_ras.size() == 4)) begin
                n_fail++; $display("FAIL rand_%0d: got pc=%h empty=%b full=%b expected pc=%h depth=%0d",
                                   i, pc, ras_empty, ras_full, m_pc, m_ras.size());
            end
`ifdef PC_RAS_ERR_EN
            n_checks++;
            if (err_ovf !== m_ovf || err_unf !== m_unf) begin
                n_fail++; $display("FAIL rand_err_%0d: got ovf=%b unf=%b expected %b %b",
                                   i, err_ovf, err_unf, m_ovf, m_unf);
            end
`endif
        end
        err_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_inc();
        test_branch_wrap();
        test_nested_call();
        test_ovf_unf();
        test_priority_stall();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
